// File: rtl/fir_cfg_pkg.sv
// Shared constants and types for the FIR configuration responder: address map,
// ap_ctrl bit positions, FSM state encodings and the address decoder.
package fir_cfg_pkg;

    localparam logic [11:0] ADDR_AP_CTRL  = 12'h000;
    localparam logic [11:0] ADDR_DATA_LEN = 12'h010;
    localparam logic [11:0] ADDR_TAP_BASE = 12'h020;

    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_WAIT = 2'd2;
    localparam logic [1:0] R_DATA = 2'd3;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_AP_CTRL,
        SEL_DATA_LEN,
        SEL_TAP
    } reg_sel_e;

    // Both channel FSMs live in one struct so a checker can bind to a single signal.
    typedef struct packed {
        logic [0:0] w_state;
        logic [1:0] r_state;
    } fsm_state_t;

    // Tap addresses must be word aligned; anything outside the map is SEL_NONE.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr, input int tap_num);
        logic [31:0] tap_end;
        reg_sel_e    sel;
        tap_end = 32'(ADDR_TAP_BASE) + 32'(tap_num * 4);
        sel     = SEL_NONE;
        if (addr == 32'(ADDR_AP_CTRL)) begin
            sel = SEL_AP_CTRL;
        end else if (addr == 32'(ADDR_DATA_LEN)) begin
            sel = SEL_DATA_LEN;
        end else if (addr >= 32'(ADDR_TAP_BASE) && addr < tap_end && addr[1:0] == 2'b00) begin
            sel = SEL_TAP;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fir_cfg_tap_mux.sv
// Tap BRAM read-port arbiter: the bus owns the port while the engine is idle,
// the engine owns it (always enabled) while a run is in progress.
module fir_cfg_tap_mux
    import fir_cfg_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              ap_idle_i,
    input  logic              bus_en_i,
    input  logic [ADDR_W-1:0] bus_ar_i,
    input  logic [ADDR_W-1:0] eng_ar_i,
    output logic              tap_en_o,
    output logic [ADDR_W-1:0] tap_ar_o
);

    always_comb begin
        if (ap_idle_i) begin
            tap_en_o = bus_en_i;
            tap_ar_o = bus_ar_i;
        end else begin
            tap_en_o = 1'b1;
            tap_ar_o = eng_ar_i;
        end
    end

endmodule

// File: rtl/fir_axil_cfg.sv
// AXI-Lite responder for the FIR configuration space (ap_ctrl, data_length and
// the tap window in the tap BRAM), plus the start/done/idle status handling.
module fir_axil_cfg
    import fir_cfg_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TAP_NUM = 11
) (
    input  logic              axis_clk,
    input  logic              axis_rst_n,
    input  logic              awvalid,
    input  logic [ADDR_W-1:0] awaddr,
    output logic              awready,
    input  logic              wvalid,
    input  logic [DATA_W-1:0] wdata,
    output logic              wready,
    input  logic              arvalid,
    input  logic [ADDR_W-1:0] araddr,
    output logic              arready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic              rready,
    output logic [3:0]        tap_WE,
    output logic              tap_EN,
    output logic [ADDR_W-1:0] tap_AW,
    output logic [ADDR_W-1:0] tap_AR,
    output logic [DATA_W-1:0] tap_Di,
    input  logic [DATA_W-1:0] tap_Do,
    input  logic [ADDR_W-1:0] eng_tap_AR,
    input  logic              eng_done,
    output logic              ap_start_o,
    output logic [DATA_W-1:0] data_length_o
);

    localparam logic [ADDR_W-1:0] TAP_BASE = ADDR_W'(ADDR_TAP_BASE);

    fsm_state_t        st_q, st_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] dlen_q, dlen_d;
    logic              ap_idle_q, ap_idle_d;
    logic              ap_done_q, ap_done_d;
    logic              ap_start_q, ap_start_d;
    logic              rd_bram_q, rd_bram_d;

    reg_sel_e          wsel, arsel, rsel;
    logic              w_fire, start_req, rd_clear, bus_en;
    logic [ADDR_W-1:0] bus_ar;
    logic [DATA_W-1:0] ctrl_word;

    assign wsel  = decode_addr(32'(waddr_q), TAP_NUM);
    assign arsel = decode_addr(32'(araddr), TAP_NUM);
    assign rsel  = decode_addr(32'(raddr_q), TAP_NUM);

    // Handshakes: the initiator holds valid and payload stable until the matching
    // ready; awready/wready pulse together once per write, arready once per read,
    // and rvalid holds rdata stable until rready is seen.
    assign w_fire    = (st_q.w_state == W_RESP);
    assign start_req = w_fire && (wsel == SEL_AP_CTRL) && wdata_q[AP_START_BIT] && ap_idle_q;
    assign rd_clear  = (st_q.r_state == R_DATA) && rready && (rsel == SEL_AP_CTRL);
    assign bus_en    = (st_q.r_state == R_ADDR) && (arsel == SEL_TAP) && ap_idle_q;
    assign bus_ar    = araddr - TAP_BASE;

    assign awready       = w_fire;
    assign wready        = w_fire;
    assign arready       = (st_q.r_state == R_ADDR);
    assign rvalid        = (st_q.r_state == R_DATA);
    assign rdata         = rdata_q;
    assign tap_WE        = (w_fire && (wsel == SEL_TAP) && ap_idle_q) ? 4'hF : 4'h0;
    assign tap_AW        = waddr_q - TAP_BASE;
    assign tap_Di        = wdata_q;
    assign ap_start_o    = ap_start_q;
    assign data_length_o = dlen_q;

    always_comb begin
        ctrl_word              = '0;
        ctrl_word[AP_DONE_BIT] = ap_done_q;
        ctrl_word[AP_IDLE_BIT] = ap_idle_q;
    end

    always_comb begin
        st_d      = st_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        rd_bram_d = rd_bram_q;

        case (st_q.w_state)
            W_IDLE: begin
                if (awvalid && wvalid) begin
                    st_d.w_state = W_RESP;
                    waddr_d      = awaddr;
                    wdata_d      = wdata;
                end
            end
            default: st_d.w_state = W_IDLE;
        endcase

        case (st_q.r_state)
            R_IDLE: begin
                if (arvalid) begin
                    st_d.r_state = R_ADDR;
                end
            end
            R_ADDR: begin
                raddr_d      = araddr;
                rd_bram_d    = bus_en;
                st_d.r_state = R_WAIT;
            end
            R_WAIT: begin
                // A tap read that could not reach the BRAM (engine busy) reads all ones.
                case (rsel)
                    SEL_AP_CTRL:  rdata_d = ctrl_word;
                    SEL_DATA_LEN: rdata_d = dlen_q;
                    SEL_TAP:      rdata_d = rd_bram_q ? tap_Do : '1;
                    default:      rdata_d = '0;
                endcase
                st_d.r_state = R_DATA;
            end
            default: begin
                if (rready) begin
                    st_d.r_state = R_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        ap_idle_d  = ap_idle_q;
        ap_done_d  = ap_done_q;
        dlen_d     = dlen_q;
        ap_start_d = start_req;
        if (w_fire && (wsel == SEL_DATA_LEN) && ap_idle_q) begin
            dlen_d = wdata_q;
        end
        if (start_req) begin
            ap_idle_d = 1'b0;
            ap_done_d = 1'b0;
        end
        if (rd_clear) begin
            ap_done_d = 1'b0;
        end
        // Applied last so a done pulse is never lost to a coincident read-clear.
        if (eng_done) begin
            ap_done_d = 1'b1;
            ap_idle_d = 1'b1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            st_q.w_state <= W_IDLE;
            st_q.r_state <= R_IDLE;
            waddr_q      <= '0;
            wdata_q      <= '0;
            raddr_q      <= '0;
            rdata_q      <= '0;
            dlen_q       <= '0;
            ap_idle_q    <= 1'b1;
            ap_done_q    <= 1'b0;
            ap_start_q   <= 1'b0;
            rd_bram_q    <= 1'b0;
        end else begin
            st_q         <= st_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            raddr_q      <= raddr_d;
            rdata_q      <= rdata_d;
            dlen_q       <= dlen_d;
            ap_idle_q    <= ap_idle_d;
            ap_done_q    <= ap_done_d;
            ap_start_q   <= ap_start_d;
            rd_bram_q    <= rd_bram_d;
        end
    end

    fir_cfg_tap_mux #(
        .ADDR_W(ADDR_W)
    ) u_tap_mux (
        .ap_idle_i(ap_idle_q),
        .bus_en_i (bus_en),
        .bus_ar_i (bus_ar),
        .eng_ar_i (eng_tap_AR),
        .tap_en_o (tap_EN),
        .tap_ar_o (tap_AR)
    );

endmodule
